// File: rtl/disp_spi.sv
// disp_spi: command-FIFO fed SPI (mode 0) master for a display panel
// Ports:
//   clk, reset              clock and synchronous active-high reset
//   disp_en, disp_DC        write strobe and data/command select of the written entry
//   disp_bus[31:0]          [25:24] byte count minus 1, [23:0] payload
//   spi_sclk, spi_mosi      SPI clock (idle low) and MSB-first data
//   spi_cs_n, spi_dc        chip select (active low) and panel D/C line
//   busy                    FIFO non-empty or transfer in progress
//   overflow                sticky dropped-write flag, live only with DISP_SPI_OVERFLOW_EN
module disp_spi #(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_en,
    input  logic        disp_DC,
    input  logic [31:0] disp_bus,
    output logic        spi_sclk,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc,
    output logic        busy,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    logic [26:0] mem [FIFO_DEPTH];
    logic [AW:0] wr, rd;
    logic        empty, full, push, pop;
    logic [26:0] head;
    logic [23:0] aligned;
    state_t      state, state_d;
    logic [23:0] sh, sh_d;
    logic [4:0]  bits, bits_d;
    logic [7:0]  div, div_d;
    logic        phase, phase_d, mosi_d, dc_d;
    logic        unused_bus;

    assign unused_bus = ^disp_bus[31:26];
    assign empty = wr == rd;
    assign full = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    assign pop = state == LOAD;
    assign push = disp_en && !reset && (!full || pop);
    assign head = mem[rd[AW-1:0]];
    // Left-justify the last N payload bytes so the first bit sent is always bit 23.
    assign aligned = head[25:24] == 2'd0 ? {head[7:0], 16'h0} :
                     head[25:24] == 2'd1 ? {head[15:0], 8'h0} : head[23:0];
    assign spi_sclk = state == SHIFT && phase;
    assign spi_cs_n = !(state == LOAD || state == SHIFT);
    assign busy = state != IDLE || !empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr[AW-1:0]] <= {disp_DC, disp_bus[25:0]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push) wr <= wr + 1'b1;
            if (pop) rd <= rd + 1'b1;
        end
    end

`ifdef DISP_SPI_OVERFLOW_EN
    logic ovf;
    always_ff @(posedge clk) begin
        if (reset) ovf <= 1'b0;
        else if (disp_en && full && !pop) ovf <= 1'b1;
    end
    assign overflow = ovf;
`else
    assign overflow = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sh <= '0;
            bits <= '0;
            div <= '0;
            phase <= 1'b0;
            spi_mosi <= 1'b0;
            spi_dc <= 1'b0;
        end else begin
            state <= state_d;
            sh <= sh_d;
            bits <= bits_d;
            div <= div_d;
            phase <= phase_d;
            spi_mosi <= mosi_d;
            spi_dc <= dc_d;
        end
    end

    // MOSI and D/C are set on the IDLE->LOAD edge so they are valid for the whole LOAD cycle.
    always_comb begin
        state_d = state;
        sh_d = sh;
        bits_d = bits;
        div_d = div;
        phase_d = phase;
        mosi_d = spi_mosi;
        dc_d = spi_dc;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_d = LOAD;
                    mosi_d = aligned[23];
                    dc_d = head[26];
                end
            end
            LOAD: begin
                state_d = SHIFT;
                sh_d = aligned;
                bits_d = head[25:24] == 2'd0 ? 5'd7 : head[25:24] == 2'd1 ? 5'd15 : 5'd23;
                div_d = DIV_MAX;
                phase_d = 1'b0;
            end
            SHIFT: begin
                if (div != 8'd0) div_d = div - 8'd1;
                else begin
                    div_d = DIV_MAX;
                    if (!phase) phase_d = 1'b1;
                    else if (bits == 5'd0) begin
                        state_d = GAP;
                        phase_d = 1'b0;
                    end else begin
                        phase_d = 1'b0;
                        sh_d = sh << 1;
                        mosi_d = sh[22];
                        bits_d = bits - 5'd1;
                    end
                end
            end
            GAP: begin
                if (div != 8'd0) div_d = div - 8'd1;
                else state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_disp_spi.sv
// tb_disp_spi: directed and random checks of disp_spi against a transaction-timing model
module tb_disp_spi;
    localparam int D = 4;
    localparam int DEPTH = 4;
`ifdef DISP_SPI_OVERFLOW_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b0, disp_en = 1'b0, disp_DC = 1'b0;
    logic [31:0] disp_bus = '0;
    logic spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, overflow;
    int n_vec = 0, n_err = 0;

    logic [26:0] mq[$];
    logic [26:0] cur = '0;
    int m_left = 0, total = 0;
    bit m_load = 1'b0;
    logic m_dc = 1'b0, m_mosi = 1'b0, m_ovf = 1'b0;

    logic prev_cs = 1'b1, prev_sclk = 1'b0;
    logic [23:0] rx = '0;
    int nrise = 0, nxfer = 0, low_cnt = 0, last_low = 0;

    disp_spi #(.CLK_DIV(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .disp_en(disp_en), .disp_DC(disp_DC), .disp_bus(disp_bus),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n), .spi_dc(spi_dc),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic int nbytes(input logic [1:0] c);
        return c == 2'd3 ? 3 : int'(c) + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Entry occupies the FSM for 1 LOAD + 16*N*D SHIFT + D GAP cycles; one IDLE cycle between entries.
    task automatic model_edge(input bit r, input bit en, input logic [26:0] w);
        int sz;
        bit pop;
        if (r) begin
            mq.delete();
            m_left = 0;
            m_load = 1'b0;
            m_ovf = 1'b0;
            m_dc = 1'b0;
            m_mosi = 1'b0;
            return;
        end
        sz = mq.size();
        pop = m_load;
        if (pop) void'(mq.pop_front());
        if (en) begin
            if (sz < DEPTH || pop) mq.push_back(w);
            else m_ovf = 1'b1;
        end
        if (m_left == 0) begin
            if (sz > 0) begin
                cur = mq[0];
                total = 1 + 16 * nbytes(cur[25:24]) * D + D;
                m_left = total;
                m_load = 1'b1;
                m_dc = cur[26];
            end
        end else begin
            m_left--;
            m_load = 1'b0;
        end
    endtask

    task automatic cycle(input bit r, input bit en, input bit dc, input logic [31:0] bus);
        int p, idx;
        logic e_cs_n, e_sclk, e_busy;
        reset = r;
        disp_en = en;
        disp_DC = dc;
        disp_bus = bus;
        @(posedge clk);
        model_edge(r, en, {dc, bus[25:0]});
        #1;
        e_cs_n = 1'b1;
        e_sclk = 1'b0;
        if (m_left > D) begin
            p = total - m_left;
            e_cs_n = 1'b0;
            e_sclk = p >= 1 && ((p - 1) / D) % 2 == 1;
            idx = 8 * nbytes(cur[25:24]) - 1 - (p == 0 ? 0 : (p - 1) / (2 * D));
            m_mosi = cur[idx];
        end
        e_busy = m_left > 0 || mq.size() > 0;
        chk("cs_n", 32'(spi_cs_n), 32'(e_cs_n));
        chk("sclk", 32'(spi_sclk), 32'(e_sclk));
        chk("mosi", 32'(spi_mosi), 32'(m_mosi));
        chk("dc", 32'(spi_dc), 32'(m_dc));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("overflow", 32'(overflow), 32'(OVF & m_ovf));
        if (!spi_cs_n && prev_cs) begin
            nxfer++;
            low_cnt = 0;
        end
        if (!spi_cs_n) low_cnt++;
        if (spi_cs_n && !prev_cs) last_low = low_cnt;
        if (spi_sclk && !prev_sclk) begin
            rx = {rx[22:0], spi_mosi};
            nrise++;
        end
        prev_cs = spi_cs_n;
        prev_sclk = spi_sclk;
    endtask

    task automatic idle(input int k);
        repeat (k) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic drain();
        int k = 0;
        while ((m_left > 0 || mq.size() > 0) && k < 20000) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            k++;
        end
        chk("drain_bound", 32'(k < 20000), 32'd1);
        idle(2);
        chk("busy_low", 32'(busy), 32'd0);
    endtask

    task automatic clear_mon();
        rx = '0;
        nrise = 0;
        nxfer = 0;
        last_low = 0;
    endtask

    initial begin
        int k;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 32'h0300_FFFF);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        idle(3);

        clear_mon();
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_00A5);
        drain();
        chk("a5_bits", 32'(rx[7:0]), 32'hA5);
        chk("a5_rises", 32'(nrise), 32'd8);
        chk("a5_cs_low", 32'(last_low), 32'd65);
        chk("a5_dc", 32'(spi_dc), 32'd0);

        clear_mon();
        cycle(1'b0, 1'b1, 1'b1, 32'h0212_3456);
        drain();
        chk("3b_bits", 32'(rx), 32'h123456);
        chk("3b_rises", 32'(nrise), 32'd24);
        chk("3b_cs_low", 32'(last_low), 32'd193);
        chk("3b_xfers", 32'(nxfer), 32'd1);
        chk("3b_dc", 32'(spi_dc), 32'd1);

        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        clear_mon();
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_0011);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'(i), 32'h0000_0020 + 32'(i));
        chk("burst_ovf", 32'(overflow), 32'(OVF));
        drain();
        chk("burst_sent", 32'(nxfer), 32'd5);

        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        clear_mon();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 32'h0000_0040 + 32'(i));
        k = 0;
        while (!m_load && k < 5000) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            k++;
        end
        chk("load_wait_bound", 32'(k < 5000), 32'd1);
        cycle(1'b0, 1'b1, 1'b1, 32'h0100_BEEF);
        chk("full_pop_push_ovf", 32'(overflow), 32'd0);
        drain();
        chk("full_pop_push_sent", 32'(nxfer), 32'd6);

        cycle(1'b0, 1'b1, 1'b0, 32'h0100_C3A1);
        idle(2 + 16 * D + D);
        cycle(1'b1, 1'b1, 1'b1, 32'h0000_00FF);
        chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("midrst_sclk", 32'(spi_sclk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        clear_mon();
        cycle(1'b0, 1'b1, 1'b0, 32'h0000_003C);
        drain();
        chk("midrst_bits", 32'(rx[7:0]), 32'h3C);
        chk("midrst_rises", 32'(nrise), 32'd8);

        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), 32'($urandom));
            if ($urandom_range(0, 15) == 0) cycle(1'b1, 1'b0, 1'b0, 32'h0);
            idle(i % 4 == 0 ? 0 : $urandom_range(0, 80));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
